// File: rtl/vga_text_pkg.sv
// Shared geometry, palette and pipeline payload types for the text-overlay pixel path.
package vga_text_pkg;

    localparam int unsigned FONT_W  = 8;
    localparam int unsigned FONT_H  = 16;
    localparam int unsigned COL_W   = $clog2(FONT_W);
    localparam int unsigned ROW_W   = $clog2(FONT_H);
    localparam int unsigned PIX_W   = 10;
    localparam int unsigned ROM_AW  = 11;
    localparam int unsigned COLOR_W = 4;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned FS_W    = 2;

    typedef enum logic [FS_W-1:0] {
        FS_NONE = 2'd0,
        FS_1X   = 2'd1,
        FS_2X   = 2'd2,
        FS_4X   = 2'd3
    } font_size_e;

    // 16-colour palette, {R4,G4,B4}; index 2 is the clock-digit green
    localparam logic [RGB_W-1:0] PALETTE [0:15] = '{
        12'h000, 12'h00A, 12'h0F0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    typedef struct packed {
        logic [COL_W-1:0]   col;
        logic [COLOR_W-1:0] color;
        logic               text_en;
        logic               video_on;
        logic               hsync;
        logic               vsync;
    } stage1_t;

    localparam stage1_t STAGE1_RST = '{
        col: '0, color: '0, text_en: 1'b0, video_on: 1'b0, hsync: 1'b1, vsync: 1'b1
    };

endpackage

// File: rtl/text_pixel_renderer_blink_timer.sv
// Counts vsync falling edges and toggles the text blank phase every BLINK_FRAMES frames.
module blink_timer
    import vga_text_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_i,
    input  logic vsync_i,
    input  logic blink_en_i,
    output logic blank_o
);

    localparam int unsigned CNT_W = 8;

    logic             vs_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             fall_c;
    logic             wrap_c;

    // The counter runs regardless of blink_en; only the phase is held clear
    always_comb begin
        fall_c  = vs_prev_q & ~vsync_i;
        wrap_c  = (cnt_q == CNT_W'(BLINK_FRAMES - 1));
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (fall_c) begin
            if (wrap_c) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (!blink_en_i) begin
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q <= 1'b1;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
        end else if (tick_i) begin
            vs_prev_q <= vsync_i;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign blank_o = phase_q;

endmodule

// File: rtl/text_pixel_renderer.sv
// Two-stage pixel pipeline: drives the external font ROM, then colours the pixel from
// the returned row word, keeping hsync/vsync aligned with rgb.
module text_pixel_renderer
    import vga_text_pkg::*;
#(
    parameter logic [RGB_W-1:0] BG_RGB       = 12'h000,
    parameter int unsigned      BLINK_FRAMES = 30
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pixel_tick,
    input  logic                video_on,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [PIX_W-1:0]    pixelx,
    input  logic [PIX_W-1:0]    pixely,
    input  logic [ROM_AW-1:0]   rom_addr_in,
    input  logic [COLOR_W-1:0]  color_addr,
    input  logic [FS_W-1:0]     font_size,
    input  logic                blink_en,
    output logic [ROM_AW-1:0]   font_rom_addr,
    input  logic [FONT_W-1:0]   font_word,
    output logic [RGB_W-1:0]    rgb,
    output logic                hsync_out,
    output logic                vsync_out
);

    logic [ROW_W-1:0]  row_c;
    logic [COL_W-1:0]  col_c;
    logic              text_en_c;
    logic [ROM_AW-1:0] addr_q, addr_d;
    stage1_t           s1_q, s1_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              hs_q, vs_q;
    logic [COL_W-1:0]  bit_idx_c;
    logic              font_bit_c;
    logic              blank_c;
    logic              unused_bits_c;

    assign unused_bits_c = ^{pixelx[PIX_W-1:5], pixely[PIX_W-1:6], rom_addr_in[ROW_W-1:0]};

    // Glyph row/column selection by scale factor
    always_comb begin
        row_c     = pixely[3:0];
        col_c     = pixelx[2:0];
        text_en_c = 1'b1;
        case (font_size_e'(font_size))
            FS_2X: begin
                row_c = pixely[4:1];
                col_c = pixelx[3:1];
            end
            FS_4X: begin
                row_c = pixely[5:2];
                col_c = pixelx[4:2];
            end
            FS_NONE: text_en_c = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        addr_d        = {rom_addr_in[ROM_AW-1:ROW_W], row_c};
        s1_d          = STAGE1_RST;
        s1_d.col      = col_c;
        s1_d.color    = color_addr;
        s1_d.text_en  = text_en_c;
        s1_d.video_on = video_on;
        s1_d.hsync    = hsync_in;
        s1_d.vsync    = vsync_in;
    end

    // Stage 2: font_word now belongs to the stage-1 address; bit 7 is the leftmost pixel
    always_comb begin
        bit_idx_c  = COL_W'(FONT_W - 1) - s1_q.col;
        font_bit_c = font_word[bit_idx_c];
        rgb_d      = BG_RGB;
        if (!s1_q.video_on) begin
            rgb_d = '0;
        end else if (s1_q.text_en && font_bit_c && !blank_c) begin
            rgb_d = PALETTE[s1_q.color];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            s1_q   <= STAGE1_RST;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else if (pixel_tick) begin
            addr_q <= addr_d;
            s1_q   <= s1_d;
            rgb_q  <= rgb_d;
            hs_q   <= s1_q.hsync;
            vs_q   <= s1_q.vsync;
        end
    end

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_i     (pixel_tick),
        .vsync_i    (vsync_in),
        .blink_en_i (blink_en),
        .blank_o    (blank_c)
    );

    assign font_rom_addr = addr_q;
    assign rgb           = rgb_q;
    assign hsync_out     = hs_q;
    assign vsync_out     = vs_q;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Directed bench for text_pixel_renderer: alignment, scaling, blanking, blink, sync delay, reset, stall.
module tb_text_pixel_renderer;

    localparam logic [11:0] BG  = 12'h123;
    localparam logic [11:0] GRN = 12'h0F0;
    localparam logic [11:0] RED = 12'hA00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pixel_tick;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  pixelx;
    logic [9:0]  pixely;
    logic [10:0] rom_addr_in;
    logic [3:0]  color_addr;
    logic [1:0]  font_size;
    logic        blink_en;
    logic [10:0] font_rom_addr;
    logic [7:0]  font_word;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    int errors = 0;
    int checks = 0;

    logic [11:0] blink_exp [4];
    logic        hist [120];

    always #5 clk = ~clk;

    text_pixel_renderer #(
        .BG_RGB       (BG),
        .BLINK_FRAMES (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pixel_tick    (pixel_tick),
        .video_on      (video_on),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .pixelx        (pixelx),
        .pixely        (pixely),
        .rom_addr_in   (rom_addr_in),
        .color_addr    (color_addr),
        .font_size     (font_size),
        .blink_en      (blink_en),
        .font_rom_addr (font_rom_addr),
        .font_word     (font_word),
        .rgb           (rgb),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one vsync falling edge, then let the pipeline settle
    task automatic vsync_edge();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        ticks(3);
    endtask

    initial begin
        blink_exp[0] = GRN;
        blink_exp[1] = BG;
        blink_exp[2] = BG;
        blink_exp[3] = GRN;

        reset_n     = 1'b1;
        pixel_tick  = 1'b1;
        video_on    = 1'b1;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        pixelx      = '0;
        pixely      = '0;
        rom_addr_in = '0;
        color_addr  = '0;
        font_size   = 2'd1;
        blink_en    = 1'b0;
        font_word   = '0;
        #2 reset_n  = 1'b0;
        ticks(2);

        check_eq("rst_rgb", 32'(rgb), 32'h000);
        check_eq("rst_addr", 32'(font_rom_addr), 32'h000);
        check_eq("rst_hs", 32'(hsync_out), 32'h1);
        check_eq("rst_vs", 32'(vsync_out), 32'h1);
        reset_n = 1'b1;

        // Pipeline alignment
        rom_addr_in = 11'h030;
        font_word   = 8'b1000_0000;
        color_addr  = 4'd2;
        font_size   = 2'd1;
        pixelx      = 10'd0;
        pixely      = 10'd0;
        tick();
        check_eq("align_addr", 32'(font_rom_addr), 32'h030);
        check_eq("align_lat1", 32'(rgb), 32'h000);
        tick();
        check_eq("align_rgb", 32'(rgb), 32'(GRN));
        pixelx = 10'd1;
        tick();
        check_eq("align_hold", 32'(rgb), 32'(GRN));
        tick();
        check_eq("align_bg", 32'(rgb), 32'(BG));

        // Scaling
        font_size  = 2'd2;
        pixely     = 10'd6;
        pixelx     = 10'd2;
        font_word  = 8'b0100_0000;
        color_addr = 4'd4;
        tick();
        check_eq("2x_addr", 32'(font_rom_addr), 32'h033);
        tick();
        check_eq("2x_px2", 32'(rgb), 32'(RED));
        pixelx = 10'd3;
        ticks(2);
        check_eq("2x_px3", 32'(rgb), 32'(RED));
        pixelx = 10'd4;
        ticks(2);
        check_eq("2x_px4", 32'(rgb), 32'(BG));
        font_size   = 2'd3;
        pixely      = 10'd13;
        rom_addr_in = 11'h03F;
        pixelx      = 10'd5;
        tick();
        check_eq("4x_addr", 32'(font_rom_addr), 32'h033);
        tick();
        check_eq("4x_px5", 32'(rgb), 32'(RED));
        pixelx = 10'd8;
        ticks(2);
        check_eq("4x_px8", 32'(rgb), 32'(BG));
        font_size = 2'd1;
        pixelx    = 10'd1;
        tick();
        check_eq("1x_addr13", 32'(font_rom_addr), 32'h03D);
        tick();
        check_eq("1x_px1", 32'(rgb), 32'(RED));

        // Blanking
        rom_addr_in = 11'h030;
        pixely      = 10'd0;
        pixelx      = 10'd0;
        font_word   = 8'b1000_0000;
        color_addr  = 4'd2;
        video_on    = 1'b0;
        ticks(2);
        check_eq("blank_video", 32'(rgb), 32'h000);
        video_on  = 1'b1;
        font_size = 2'd0;
        pixely    = 10'd5;
        tick();
        check_eq("none_addr", 32'(font_rom_addr), 32'h035);
        tick();
        check_eq("none_rgb", 32'(rgb), 32'(BG));
        font_size = 2'd1;
        pixely    = 10'd0;

        // Blink with BLINK_FRAMES = 2
        blink_en = 1'b1;
        ticks(2);
        check_eq("blink_pre", 32'(rgb), 32'(GRN));
        for (int e = 0; e < 4; e++) begin
            vsync_edge();
            check_eq($sformatf("blink_e%0d", e + 1), 32'(rgb), 32'(blink_exp[e]));
        end
        blink_en = 1'b0;
        vsync_edge();
        check_eq("blink_off_e5", 32'(rgb), 32'(GRN));
        blink_en = 1'b1;
        vsync_edge();
        check_eq("blink_on_e6", 32'(rgb), 32'(BG));
        blink_en = 1'b0;
        ticks(3);
        check_eq("blink_forced", 32'(rgb), 32'(GRN));

        // Sync delay: 96-tick hsync pulse
        for (int i = 0; i < 120; i++) begin
            hsync_in = !(i >= 10 && i < 106);
            hist[i]  = hsync_in;
            tick();
            if (i >= 1) check_eq($sformatf("hs_dly%0d", i), 32'(hsync_out), 32'(hist[i-1]));
        end

        // Reset asserted mid-line
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        ticks(2);
        check_eq("pre_rst_rgb", 32'(rgb), 32'(GRN));
        check_eq("pre_rst_hs", 32'(hsync_out), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rgb", 32'(rgb), 32'h000);
        check_eq("async_hs", 32'(hsync_out), 32'h1);
        check_eq("async_vs", 32'(vsync_out), 32'h1);
        check_eq("async_addr", 32'(font_rom_addr), 32'h000);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_t1", 32'(rgb), 32'h000);
        tick();
        check_eq("post_rst_t2", 32'(rgb), 32'(GRN));

        // Stall: pixel_tick low for 5 clocks
        pixel_tick  = 1'b0;
        pixelx      = 10'd1;
        hsync_in    = 1'b0;
        rom_addr_in = 11'h050;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("stall_rgb%0d", i), 32'(rgb), 32'(GRN));
            check_eq($sformatf("stall_hs%0d", i), 32'(hsync_out), 32'h1);
            check_eq($sformatf("stall_addr%0d", i), 32'(font_rom_addr), 32'h030);
        end
        pixel_tick = 1'b1;
        tick();
        check_eq("resume_addr", 32'(font_rom_addr), 32'h050);
        check_eq("resume_rgb1", 32'(rgb), 32'(GRN));
        tick();
        check_eq("resume_rgb2", 32'(rgb), 32'(BG));
        check_eq("resume_hs", 32'(hsync_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
